mem_port_arbiter: RTL

Two-requester arbiter that shares the single RV32I memory port between the instruction-fetch path and the load/store path. It sits between the processor's memory-side signals and the one physical memory (or cache) port. It serializes accesses, latches the winning command, holds it until the memory responds, and returns a registered one-cycle response to the requester that was granted. Both sides use the existing memory protocol: the request is held high until the response is seen.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle shared by the fetch requester, the load/store requester
// and the single physical memory port.
// master: processor/memory environment view; slave: arbiter view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  i_read;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wmask;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_resp;
  logic                  m_read;
  logic                  m_write;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wmask;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_resp;

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata, m_wmask
  );

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata, m_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// and load/store. The winning command is registered and held until m_resp,
// then a registered one-cycle response goes back to the granted side.
// Optional macro ARB_RR_EN: round-robin tie-break (default: data wins ties).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned MaskW = DATA_W / 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusyI = 2'd1;
  localparam logic [1:0] StBusyD = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [MaskW-1:0]  m_wmask_q, m_wmask_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic i_req, d_req, pick_d, tie_pick_d;

  assign i_req  = bus.i_read;
  assign d_req  = bus.d_read | bus.d_write;
  assign pick_d = d_req & (~i_req | tie_pick_d);

`ifdef ARB_RR_EN
  // last_d_q set means data won the most recent grant
  logic last_d_q, last_d_d;
  assign tie_pick_d = ~last_d_q;

  // Round-robin history; reset to data so instruction wins the first tie
  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b1;
    else     last_d_q <= last_d_d;
  end
`else
  assign tie_pick_d = 1'b1;
`endif

  // Next-state: grant in idle, wait for memory, pulse response, back to idle
  always_comb begin
    state_d   = state_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
`ifdef ARB_RR_EN
    last_d_d  = last_d_q;
`endif
    case (state_q)
      StIdle: begin
        if (i_req | d_req) begin
          if (pick_d) begin
            // Write takes precedence when both read and write are raised
            m_read_d  = ~bus.d_write;
            m_write_d = bus.d_write;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_wmask_d = bus.d_write ? bus.d_wmask : '0;
            state_d   = StBusyD;
          end else begin
            m_read_d  = 1'b1;
            m_write_d = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
            m_wmask_d = '0;
            state_d   = StBusyI;
          end
`ifdef ARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end
      StBusyI, StBusyD: begin
        if (bus.m_resp) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = StResp;
          if (state_q == StBusyD) begin
            d_rdata_d = bus.m_rdata;
            d_resp_d  = 1'b1;
          end else begin
            i_rdata_d = bus.m_rdata;
            i_resp_d  = 1'b1;
          end
        end
      end
      // Requests are ignored here so a dropping requester is not re-granted
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any in-flight command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wmask = m_wmask_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_resp  = i_resp_q;
  assign bus.d_resp  = d_resp_q;
endmodule
